kbd_event_decoder: RTL
======================

Name: kbd_event_decoder

Overview:
Second-generation PS/2 scan-code decoder that sits between the PS/2 byte receiver and the CPU/MMIO keyboard port. It decodes set-2 make, break, E0-extended and E1 (Pause) sequences into typed key events. Events are queued in a parametrised FIFO so that no keystroke is lost between software polls. Overflow reporting is sticky, and an optional typematic (auto-repeat) filter can be compiled in.

Parameters:
FIFO_DEPTH, 8, event queue depth; power of two, >=2
PAUSE_SKIP_LEN, 7, bytes swallowed after an E1 prefix (Pause sequence tail)

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
rx_data  in  8  byte from PS/2 receiver
rx_valid  in  1  one-cycle strobe; rx_data is valid
rx_overflow  in  1  receiver lost bytes; one-cycle strobe
ev_data  out  10  head event {brk, ext, code[7:0]}; first-word-fall-through
ev_valid  out  1  FIFO non-empty
ev_pop  in  1  consume head event
ev_count  out  $clog2(FIFO_DEPTH+1)  events queued
overflow  out  1  sticky: event dropped or receiver overflow
clr_ovf  in  1  clears overflow

Behaviour:
- Reset (clrn=0, async): FSM=IDLE, FIFO empty, ev_valid=0, ev_data=0, ev_count=0, overflow=0, skip counter=0, held bitmap cleared.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP. The FSM advances only on cycles where rx_valid=1.
  - IDLE:
    - F0 -> GOT_F0.
    - E0 -> GOT_E0.
    - E1 -> push {0,1,8'h77} (Pause); load counter with PAUSE_SKIP_LEN; go to SKIP.
    - 00 or FF (keyboard error) -> discard.
    - Any other byte -> push {0,0,byte}.
  - GOT_E0:
    - F0 -> GOT_E0F0.
    - E0 -> stay.
    - 12 (fake shift) -> discard, go to IDLE.
    - Else -> push {0,1,byte}, go to IDLE.
  - GOT_F0:
    - E0, F0 or E1 (malformed) -> discard, go to IDLE.
    - Else -> push {1,0,byte}, go to IDLE.
  - GOT_E0F0:
    - 12 -> discard, go to IDLE.
    - E0, F0 or E1 -> discard, go to IDLE.
    - Else -> push {1,1,byte}, go to IDLE.
  - SKIP: each byte decrements the counter; after the byte that brings it to 0, go to IDLE. No event is pushed.
- rx_overflow=1: FSM forced to IDLE, counter cleared, overflow set. If rx_valid is high in the same cycle, that byte is dropped.
- Latency: byte strobed in cycle N -> event visible on ev_data/ev_valid in cycle N+1 (registered push, FWFT read).
- FIFO rules:
  - Push when full and ev_pop=0: event dropped, overflow<=1, contents unchanged.
  - Push and pop in the same cycle when full: both succeed, ev_count unchanged.
  - Pop when empty: ignored, no underflow.
  - Pointers are log2(FIFO_DEPTH) bits, wrap naturally; full/empty derive from ev_count.
- Overflow flag: if set and clear occur in the same cycle, set wins.
- ev_data holds the last head value when empty; consumers qualify it with ev_valid.

Optional Feature:
KBD_TYPEMATIC_FILTER_EN
- Defined: adds a 512-bit held bitmap indexed {ext, code}.
  - A make whose bit is already set is discarded, so auto-repeat is suppressed.
  - A make sets the bit; a break clears the bit and is always pushed.
  - The Pause event is never filtered.
  - rx_overflow clears the whole bitmap.
  - A make that is dropped because the FIFO is full still sets the bit.
- Undefined: no bitmap; every decoded make is pushed, so typematic repeats appear as repeated make events.

Decomposition:
- Package kbd_pkg:
  - typedef kbd_event_t, packed {logic brk; logic ext; logic [7:0] code}.
  - Enum kbd_state_t.
  - Constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_PAUSE=8'hE1, SC_FAKE_SHIFT=8'h12, SC_ERR0=8'h00, SC_ERR1=8'hFF, PAUSE_CODE=8'h77.
- Sub-module kbd_event_fifo (parametrised FIFO_DEPTH, element kbd_event_t, FWFT, push/pop/count/full). Decoder FSM and filter stay in the top.

Test Plan:
- Bytes 1C, F0, 1C, no pops -> ev_count=2; pops return 0x01C then 0x21C; ev_valid drops after the second pop.
- Bytes E0, 75, E0, F0, 75 -> events 0x175 then 0x375; E0 12 E0 75 -> only 0x175 (fake shift dropped).
- Bytes E1 14 77 E1 F0 14 F0 77 then 1C -> exactly two events, 0x177 then 0x01C; FSM back in IDLE.
- FIFO_DEPTH=8, push 9 makes with no pop -> ev_count=8, overflow=1, ninth event lost. Full plus simultaneous push/pop -> count stays 8 and order is preserved. clr_ovf -> overflow=0.
- Byte E0 then rx_overflow, then byte 75 -> single event 0x075, overflow=1. Async clrn low mid-sequence -> all outputs 0 immediately.
- With KBD_TYPEMATIC_FILTER_EN, bytes 1C 1C 1C F0 1C 1C -> events 0x01C, 0x21C, 0x01C. Without the macro -> 0x01C x3, 0x21C, 0x01C.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and scan-code constants for the PS/2 set-2 event decoder.
//   kbd_event_t : one decoded key event {brk, ext, code}
//   kbd_state_t : decoder FSM states
package kbd_pkg;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } kbd_event_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_SKIP
  } kbd_state_t;

  localparam logic [7:0] SC_BREAK      = 8'hF0;
  localparam logic [7:0] SC_EXT        = 8'hE0;
  localparam logic [7:0] SC_PAUSE      = 8'hE1;
  localparam logic [7:0] SC_FAKE_SHIFT = 8'h12;
  localparam logic [7:0] SC_ERR0       = 8'h00;
  localparam logic [7:0] SC_ERR1       = 8'hFF;
  localparam logic [7:0] PAUSE_CODE    = 8'h77;

endpackage

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: first-word-fall-through queue of kbd_event_t.
//   clk, clrn   : clock, async active-low reset
//   push, push_data : enqueue (accepted when not full, or when popping in the same cycle)
//   pop         : dequeue head (ignored when empty)
//   head        : registered head; holds the last head value once the queue drains
//   valid       : queue non-empty
//   count       : number of queued events
//   full        : count == FIFO_DEPTH
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push,
  input  kbd_event_t       push_data,
  input  logic             pop,
  output kbd_event_t       head,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  kbd_event_t       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nx;
  logic [CNT_W-1:0] count_nx;
  kbd_event_t       head_nx;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_C);
  assign valid   = (count != '0);
  assign pop_ok  = pop && valid;
  assign push_ok = push && (!full || pop);

  assign rd_ptr_nx = pop_ok ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    count_nx = count;
    if (push_ok && !pop_ok)
      count_nx = count + CNT_W'(1);
    else if (!push_ok && pop_ok)
      count_nx = count - CNT_W'(1);
  end

  // The next head is either already in memory or is the element being
  // written this cycle; the latter only when it ends up as the sole entry.
  always_comb begin
    head_nx = head;
    if (count_nx != '0) begin
      if (push_ok && (rd_ptr_nx == wr_ptr))
        head_nx = push_data;
      else
        head_nx = mem[rd_ptr_nx];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nx;
      count  <= count_nx;
      head   <= head_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/kbd_event_decoder.sv
// kbd_event_decoder: PS/2 set-2 scan-code decoder feeding an event FIFO.
//   clk, clrn     : clock, async active-low reset
//   rx_data/rx_valid/rx_overflow : byte stream from the PS/2 receiver
//   ev_data       : head event {brk, ext, code}, FWFT
//   ev_valid      : event available
//   ev_pop        : consume head event
//   ev_count      : events queued
//   overflow      : sticky drop/receiver-overflow flag, cleared by clr_ovf
// Optional build macro KBD_TYPEMATIC_FILTER_EN adds a held-key bitmap that
// suppresses auto-repeat makes.
//
// state       | meaning
// ST_IDLE     | waiting for the first byte of a sequence
// ST_GOT_E0   | extended prefix seen
// ST_GOT_F0   | break prefix seen
// ST_GOT_E0F0 | extended break prefix seen
// ST_SKIP     | swallowing the tail of a Pause sequence
module kbd_event_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PAUSE_SKIP_LEN = 7,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_overflow,
  output logic [9:0]       ev_data,
  output logic             ev_valid,
  input  logic             ev_pop,
  output logic [CNT_W-1:0] ev_count,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int SKIP_W = ($clog2(PAUSE_SKIP_LEN + 1) < 1) ? 1 : $clog2(PAUSE_SKIP_LEN + 1);
  localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(PAUSE_SKIP_LEN);

  kbd_state_t        state;
  kbd_state_t        state_nx;
  logic [SKIP_W-1:0] skip_cnt;
  logic [SKIP_W-1:0] skip_nx;
  logic              dec_push;
  logic              dec_pause;
  kbd_event_t        dec_ev;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_drop;
  kbd_event_t        fifo_head;

  // Decode is combinational so a byte strobed in cycle N is written into the
  // FIFO at the end of cycle N and visible at its head in cycle N+1.
  always_comb begin
    state_nx  = state;
    skip_nx   = skip_cnt;
    dec_push  = 1'b0;
    dec_pause = 1'b0;
    dec_ev    = '0;
    if (rx_overflow) begin
      state_nx = ST_IDLE;
      skip_nx  = '0;
    end else if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == SC_BREAK)
            state_nx = ST_GOT_F0;
          else if (rx_data == SC_EXT)
            state_nx = ST_GOT_E0;
          else if (rx_data == SC_PAUSE) begin
            dec_push    = 1'b1;
            dec_pause   = 1'b1;
            dec_ev.ext  = 1'b1;
            dec_ev.code = PAUSE_CODE;
            skip_nx     = SKIP_LOAD;
            state_nx    = (PAUSE_SKIP_LEN == 0) ? ST_IDLE : ST_SKIP;
          end else if (rx_data != SC_ERR0 && rx_data != SC_ERR1) begin
            dec_push    = 1'b1;
            dec_ev.code = rx_data;
          end
        end
        ST_GOT_E0: begin
          if (rx_data == SC_BREAK)
            state_nx = ST_GOT_E0F0;
          else if (rx_data == SC_EXT)
            state_nx = ST_GOT_E0;
          else begin
            state_nx = ST_IDLE;
            if (rx_data != SC_FAKE_SHIFT) begin
              dec_push    = 1'b1;
              dec_ev.ext  = 1'b1;
              dec_ev.code = rx_data;
            end
          end
        end
        ST_GOT_F0: begin
          state_nx = ST_IDLE;
          if (rx_data != SC_EXT && rx_data != SC_BREAK && rx_data != SC_PAUSE) begin
            dec_push    = 1'b1;
            dec_ev.brk  = 1'b1;
            dec_ev.code = rx_data;
          end
        end
        ST_GOT_E0F0: begin
          state_nx = ST_IDLE;
          if (rx_data != SC_FAKE_SHIFT && rx_data != SC_EXT &&
              rx_data != SC_BREAK && rx_data != SC_PAUSE) begin
            dec_push    = 1'b1;
            dec_ev.brk  = 1'b1;
            dec_ev.ext  = 1'b1;
            dec_ev.code = rx_data;
          end
        end
        ST_SKIP: begin
          if (skip_cnt <= SKIP_W'(1)) begin
            skip_nx  = '0;
            state_nx = ST_IDLE;
          end else begin
            skip_nx = skip_cnt - SKIP_W'(1);
          end
        end
        default: begin
          state_nx = ST_IDLE;
          skip_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nx;
      skip_cnt <= skip_nx;
    end
  end

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic [511:0] held;
  logic [8:0]   held_idx;

  assign held_idx = {dec_ev.ext, dec_ev.code};

  // A repeated make of a key already held is suppressed; the bit is set by
  // the decoded make even if the FIFO later has to drop it.
  always_comb begin
    fifo_push = dec_push;
    if (dec_push && !dec_pause && !dec_ev.brk && held[held_idx])
      fifo_push = 1'b0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      held <= '0;
    else if (rx_overflow)
      held <= '0;
    else if (dec_push && !dec_pause)
      held[held_idx] <= !dec_ev.brk;
  end
`else
  assign fifo_push = dec_push;
`endif

  assign fifo_drop = fifo_push && fifo_full && !ev_pop;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      overflow <= 1'b0;
    else if (rx_overflow || fifo_drop)
      overflow <= 1'b1;
    else if (clr_ovf)
      overflow <= 1'b0;
  end

  kbd_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (fifo_push),
    .push_data (dec_ev),
    .pop       (ev_pop),
    .head      (fifo_head),
    .valid     (ev_valid),
    .count     (ev_count),
    .full      (fifo_full)
  );

  assign ev_data = fifo_head;

endmodule
